// File: rtl/alu_instr_decoder_pkg.sv
// Shared types for the ALU instruction decode stage: opcodes, instruction
// classes, the decoded FIFO entry and the func3 legality limits.
package alu_instr_decoder_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,  ALU_XOR, ALU_NOT,
        ALU_SLL, ALU_SRL, ALU_SLA, ALU_SRA,
        ALU_EQ,  ALU_GRT, ALU_GTU, ALU_GTE, ALU_LTE, ALU_GEU, ALU_LEU,
        ALU_BSL
    } alu_opcode_t;

    typedef enum logic [3:0] {
        CLS_RTYPE = 4'd0,
        CLS_SHIFT = 4'd1,
        CLS_CMP   = 4'd2,
        CLS_ADDI  = 4'd3,
        CLS_LUI   = 4'd4
    } instr_class_t;

    typedef struct packed {
        alu_opcode_t      alu_op;
        logic [2:0]       rd;
        logic [2:0]       rs1;
        logic [2:0]       rs2;
        logic [WIDTH-1:0] imm;
        logic             use_imm;
        logic             is_cmp;
        logic             wr_en;
    } dec_entry_t;

    // First illegal func3 per class; every func3 at or above it is rejected.
    localparam logic [2:0] RTYPE_F3_ILLEGAL = 3'd6;
    localparam logic [2:0] SHIFT_F3_ILLEGAL = 3'd4;
    localparam logic [2:0] CMP_F3_ILLEGAL   = 3'd7;

endpackage

// File: rtl/alu_instr_decode_comb.sv
// Purely combinational decode of one 16-bit instruction word into a
// dec_entry_t plus an illegal-encoding flag.
module alu_instr_decode_comb
    import alu_instr_decoder_pkg::*;
(
    input  logic [15:0] instr_i,
    output dec_entry_t  entry_o,
    output logic        illegal_o
);

    instr_class_t cls;
    logic [2:0]   func3;

    assign cls   = instr_class_t'(instr_i[15:12]);
    assign func3 = instr_i[2:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        entry_o     = '0;
        entry_o.rd  = instr_i[11:9];
        entry_o.rs1 = instr_i[8:6];
        entry_o.rs2 = instr_i[5:3];
        illegal_o   = 1'b0;

        case (cls)
            CLS_RTYPE: begin
                entry_o.wr_en = 1'b1;
                illegal_o     = (func3 >= RTYPE_F3_ILLEGAL);
                case (func3)
                    3'd1:    entry_o.alu_op = ALU_SUB;
                    3'd2:    entry_o.alu_op = ALU_AND;
                    3'd3:    entry_o.alu_op = ALU_OR;
                    3'd4:    entry_o.alu_op = ALU_XOR;
                    3'd5:    entry_o.alu_op = ALU_NOT;
                    default: entry_o.alu_op = ALU_ADD;
                endcase
            end
            CLS_SHIFT: begin
                entry_o.wr_en = 1'b1;
                illegal_o     = (func3 >= SHIFT_F3_ILLEGAL);
                case (func3)
                    3'd1:    entry_o.alu_op = ALU_SRL;
                    3'd2:    entry_o.alu_op = ALU_SLA;
                    3'd3:    entry_o.alu_op = ALU_SRA;
                    default: entry_o.alu_op = ALU_SLL;
                endcase
            end
            CLS_CMP: begin
                entry_o.is_cmp = 1'b1;
                illegal_o      = (func3 == CMP_F3_ILLEGAL);
                case (func3)
                    3'd1:    entry_o.alu_op = ALU_GRT;
                    3'd2:    entry_o.alu_op = ALU_GTU;
                    3'd3:    entry_o.alu_op = ALU_GTE;
                    3'd4:    entry_o.alu_op = ALU_LTE;
                    3'd5:    entry_o.alu_op = ALU_GEU;
                    3'd6:    entry_o.alu_op = ALU_LEU;
                    default: entry_o.alu_op = ALU_EQ;
                endcase
            end
            CLS_ADDI: begin
                entry_o.alu_op  = ALU_ADD;
                entry_o.use_imm = 1'b1;
                entry_o.wr_en   = 1'b1;
                entry_o.imm     = {{(WIDTH-6){instr_i[5]}}, instr_i[5:0]};
            end
            CLS_LUI: begin
                entry_o.alu_op  = ALU_BSL;
                entry_o.use_imm = 1'b1;
                entry_o.wr_en   = 1'b1;
                entry_o.rs1     = 3'd0;
                entry_o.imm     = {{(WIDTH-8){1'b0}}, instr_i[7:0]};
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_instr_decoder.sv
// Decode stage in front of the ALU: decodes accepted words into a 2-entry
// FIFO, pulses on illegal words, counts legal words and supports flush.
module alu_instr_decoder
    import alu_instr_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_opcode_t      alu_op,
    output logic [2:0]       rd,
    output logic [2:0]       rs1,
    output logic [2:0]       rs2,
    output logic [WIDTH-1:0] imm,
    output logic             use_imm,
    output logic             is_cmp,
    output logic             wr_en,
    output logic             illegal_instr,
    output logic [15:0]      dec_count
);

    dec_entry_t dec_entry;
    logic       dec_illegal;

    alu_instr_decode_comb u_decode (
        .instr_i   (instr),
        .entry_o   (dec_entry),
        .illegal_o (dec_illegal)
    );

    dec_entry_t  fifo_q [2];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q, in_ready_d;
    logic        illegal_q, illegal_d;
    logic [15:0] dec_count_q, dec_count_d;
    logic        accept, push, pop;

    assign accept = in_valid && in_ready_q;
    assign push   = accept && !dec_illegal && !flush;
    assign pop    = (count_q != 2'd0) && out_ready && !flush;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        dec_count_d = dec_count_q;
        illegal_d   = accept && dec_illegal && !flush;

        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (pop) begin
                head_d = ~head_q;
            end
            if (push) begin
                tail_d      = ~tail_q;
                dec_count_d = dec_count_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        // Registered from next-state count so out_ready never reaches in_ready combinationally.
        in_ready_d = (count_d != 2'd2);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            illegal_q   <= 1'b0;
            dec_count_q <= 16'd0;
            // NOTE: the storage is reset because the head fields are visible
            // outputs and must read zero (ALU_ADD) out of reset.
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            illegal_q   <= illegal_d;
            dec_count_q <= dec_count_d;
            if (push) begin
                fifo_q[tail_q] <= dec_entry;
            end
        end
    end

    dec_entry_t head;
    assign head = fifo_q[head_q];

    assign in_ready      = in_ready_q;
    assign out_valid     = (count_q != 2'd0);
    assign illegal_instr = illegal_q;
    assign dec_count     = dec_count_q;
    assign alu_op        = head.alu_op;
    assign rd            = head.rd;
    assign rs1           = head.rs1;
    assign rs2           = head.rs2;
    assign imm           = head.imm;
    assign use_imm       = head.use_imm;
    assign is_cmp        = head.is_cmp;
    assign wr_en         = head.wr_en;

endmodule

// File: doc/alu_instr_decoder.md
# alu_instr_decoder

Sequential decode stage that sits in front of the ALU. It accepts 16-bit instruction words over a valid/ready handshake and decodes each one into an alu_opcode_t, register selects and a sign- or zero-extended immediate. Results are buffered in a 2-entry skid FIFO so the decoder can feed the execute stage with backpressure. It also flags illegal encodings and supports a pipeline flush.

## Interface
- WIDTH, 16, datapath/immediate width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  decoder can accept (registered)
- instr  in  16  instruction word
- flush  in  1  synchronous: drop all buffered entries
- out_valid  out  1  decoded entry at FIFO head
- out_ready  in  1  execute stage consumes head
- alu_op  out  alu_opcode_t  ALU opcode
- rd, rs1, rs2  out  3 each  register selects
- imm  out  WIDTH  immediate
- use_imm  out  1  ALU b operand = imm
- is_cmp  out  1  compare op; result on ALU comp
- wr_en  out  1  write ALU out to rd
- illegal_instr  out  1  one-cycle pulse per rejected word
- dec_count  out  16  count of legal words enqueued, wraps

## Operation
- Field map: [15:12] class, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] func3.
- Class 0: R-type, wr_en=1.
  - func3 0..5 map to ADD, SUB, AND, OR, XOR, NOT.
  - func3 6..7 are illegal.
- Class 1: shifts, wr_en=1.
  - func3 0..3 map to SLL, SRL, SLA, SRA.
  - func3 4..7 are illegal.
- Class 2: compare, is_cmp=1, wr_en=0.
  - func3 0..6 map to EQ, GRT, GTU, GTE, LTE, GEU, LEU.
  - func3 7 is illegal.
- Class 3: ADDI. op=ALU_ADD, use_imm=1, imm = sign-extended instr[5:0], wr_en=1.
- Class 4: LUI. op=ALU_BSL, use_imm=1, imm = zero-extended instr[7:0], rs1=0, wr_en=1.
- Classes 5..15 are illegal.
- For non-immediate ops: imm=0, use_imm=0.
- Illegal word:
  - The handshake completes and the word is consumed.
  - Nothing is enqueued.
  - illegal_instr pulses high the next cycle.
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- FIFO: 2 entries, head pointer, tail pointer, count 0..2.
  - in_ready = (count < 2), evaluated at end of previous cycle.
  - A simultaneous push and pop leaves count unchanged.
- flush: the next state is count=0 and pointers=0.
  - A same-cycle accept is discarded and no illegal pulse is produced.
  - A same-cycle pop is ignored.
- dec_count increments once per enqueued legal word and wraps 0xFFFF→0. It is not cleared by flush.
- Reset (async, rst_n=0): count=0, out_valid=0, in_ready=1, illegal_instr=0, dec_count=0. Head fields read 0, alu_op=ALU_ADD.

## Timing
- Latency: a word accepted in cycle N has out_valid=1 in cycle N+1 if the FIFO was empty.
- Throughput: 1 word per cycle while out_ready=1.
- Output fields come directly from the FIFO head register, with no combinational path from instr.
- in_ready has no combinational path from out_ready.
- Full (count=2): in_ready=0 the cycle after becoming full, even if a pop occurs that cycle. It rises the cycle after count drops.
- Empty: out_valid=0. Head fields hold their last values, and the bench must ignore them.
- Reset asserted mid-transfer clears state immediately. The first accept is possible on the first clk edge after rst_n rises.

## Structure
- The typedefs package gains:
  - instr_class_t (4-bit enum CLS_RTYPE, CLS_SHIFT, CLS_CMP, CLS_ADDI, CLS_LUI)
  - dec_entry_t packed struct {alu_op, rd, rs1, rs2, imm, use_imm, is_cmp, wr_en}
  - ILLEGAL func3 constants
- alu_opcode_t is reused unchanged.
- One sub-module, alu_instr_decode_comb: purely combinational instr → {dec_entry_t, illegal}.
- The top holds the FIFO, counters and pulse register.

## Test plan
- Reset, then instr=0x0299 with in_valid=1 for one cycle → next cycle out_valid=1, alu_op=ALU_SUB, rd=1, rs1=2, rs2=3, use_imm=0, wr_en=1, dec_count=1.
- 0x34FF → ALU_ADD, rd=2, rs1=3, imm=0xFFFF, use_imm=1. Then 0x4AAB → ALU_BSL, rd=5, imm=0x00AB.
- 0x2056 → alu_op=LEU, rs1=1, rs2=2, is_cmp=1, wr_en=0.
- 0x0006, then 0x5000 → in_ready stays 1, out_valid stays 0, illegal_instr pulses once per word, dec_count unchanged.
- Hold out_ready=0 and stream 3 words:
  - in_ready falls after the 2nd accept and the 3rd word is held.
  - Raising out_ready drains the words in order with no loss or duplication.
- With 2 entries buffered, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, the third word is discarded, and dec_count is unchanged by the discarded word.
